// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//   txState_e    : transmitter FSM encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//   delayFrames(): clocks per serial bit, (FMAX_MHz*1000000)/BaudRate
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_e;

  // Clock cycles per bit. The receiver uses the same formula, so both ends agree.
  function automatic int delayFrames(input logic [31:0] fmaxMhz, input logic [31:0] baudRate);
    return int'((fmaxMhz * 32'd1000000) / baudRate);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO with first-word fall-through output.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : enqueue din on a rising edge; ignored while full
//   pop        : dequeue the head entry; ignored while empty
//   dout       : head entry, valid whenever !empty
//   full/empty : occupancy flags
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  // A push into a full FIFO is dropped here, so a writer can never overwrite.
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits wide and wrap on their own.
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;  // idle, or push and pop together: occupancy unchanged
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only read after it has
  // been written, and leaving it out lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  assign dout  = mem[rdPtr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered -- buffered UART transmitter for the console.
// Bytes arrive over a valid/ready handshake, wait in a FIFO, and are
// shifted out LSB-first as 8N1 frames (8E1 when UART_TX_PARITY_EN is defined).
//   clk          : system clock, all state on the rising edge
//   rst_n        : asynchronous active-low reset; aborts any frame in flight
//   wdata        : byte to send
//   wdata_valid  : wdata is valid
//   wdata_ready  : FIFO can take a byte (not full)
//   uart_tx      : registered serial line, idle high
//   busy         : frame in flight or bytes still queued
// Build option: define UART_TX_PARITY_EN to append an even-parity bit.
module uart_tx_buffered #(
  parameter logic [31:0] FMAX_MHz   = 32'd27,
  parameter logic [31:0] BaudRate   = 32'd115200,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wdata,
  input  logic       wdata_valid,
  output logic       wdata_ready,
  output logic       uart_tx,
  output logic       busy
);

  import uart_pkg::*;

  localparam int DelayFrames = delayFrames(FMAX_MHz, BaudRate);
  localparam int CW = (DelayFrames > 1) ? $clog2(DelayFrames) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(DelayFrames - 1);

  txState_e      state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [2:0]    bitIdx, bitIdxNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          txReg, txNext;
  logic          lastTick;
  logic          startFrame;
  logic          fifoEmpty, fifoFull;
  logic [7:0]    fifoDout;
`ifdef UART_TX_PARITY_EN
  logic          parityBit, parityNext;
`endif

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wdata_valid),
    .pop   (startFrame),
    .din   (wdata),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign lastTick = (cnt == LastCnt);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    stateNext  = state;
    cntNext    = cnt;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    startFrame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parityNext = parityBit;
`endif
    case (state)
      IDLE: startFrame = !fifoEmpty;
      START: begin
        if (lastTick) begin
          cntNext    = '0;
          bitIdxNext = '0;
          stateNext  = DATA;
        end else cntNext = cnt + CW'(1);
      end
      DATA: begin
        if (lastTick) begin
          cntNext   = '0;
          shiftNext = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end else bitIdxNext = bitIdx + 3'd1;
        end else cntNext = cnt + CW'(1);
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (lastTick) begin
          cntNext   = '0;
          stateNext = STOP;
        end else cntNext = cnt + CW'(1);
      end
`endif
      STOP: begin
        if (lastTick) begin
          cntNext = '0;
          // Chain straight into the next start bit so queued frames stay contiguous.
          if (!fifoEmpty) startFrame = 1'b1;
          else            stateNext  = IDLE;
        end else cntNext = cnt + CW'(1);
      end
      default: stateNext = IDLE;
    endcase

    if (startFrame) begin
      shiftNext = fifoDout;
      cntNext   = '0;
      stateNext = START;
`ifdef UART_TX_PARITY_EN
      parityNext = ^fifoDout;
`endif
    end
  end

  // The pin level is derived from the next state so the registered output
  // changes on the same edge as the state, with no extra cycle of delay.
  always_comb begin
    txNext = 1'b1;
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txNext = parityNext;
`endif
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
`ifdef UART_TX_PARITY_EN
      parityBit <= parityNext;
`endif
    end
  end

  assign uart_tx     = txReg;
  assign busy        = (state != IDLE) || !fifoEmpty;
  assign wdata_ready = !fifoFull;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered -- self-checking bench for uart_tx_buffered.
// FMAX_MHz=1, BaudRate=100000 gives 10 clocks per bit. A queue-based model
// predicts the line level, busy and wdata_ready every cycle; a bench-side
// receiver decodes the line and its bytes are compared with the model's log.
module tb_uart_tx_buffered;

  localparam int D     = 10;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11 * D;
`else
  localparam int FRAME = 10 * D;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] wdata = 8'h00;
  logic       wdata_valid = 1'b0;
  logic       wdata_ready;
  logic       uart_tx;
  logic       busy;

  uart_tx_buffered #(
    .FMAX_MHz   (32'd1),
    .BaudRate   (32'd100000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .uart_tx     (uart_tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] pendQ[$];   // bytes accepted but not yet started
  bit         lineQ[$];   // remaining line levels of the frame in flight, one per clock
  logic [7:0] logQ[$];    // bytes whose frames were started and not aborted
  logic [7:0] rxQ[$];     // bytes decoded from the line
  logic       mAccept = 1'b0;

  function automatic bit modelStep(input logic v, input logic [7:0] d);
    bit         acc;
    logic [7:0] b;
    acc = v && (pendQ.size() < DEPTH);
    if (lineQ.size() > 0) void'(lineQ.pop_front());
    if (lineQ.size() == 0 && pendQ.size() > 0) begin
      b = pendQ.pop_front();
      logQ.push_back(b);
      for (int k = 0; k < D; k++) lineQ.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < D; k++) lineQ.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
      for (int k = 0; k < D; k++) lineQ.push_back(^b);
`endif
      for (int k = 0; k < D; k++) lineQ.push_back(1'b1);
    end
    if (acc) pendQ.push_back(d);
    return acc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (lineQ.size() > 0) void'(logQ.pop_back());
      lineQ.delete();
      pendQ.delete();
      mAccept <= 1'b0;
    end else begin
      mAccept <= modelStep(wdata_valid, wdata);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("uart_tx", 32'(uart_tx), 32'((lineQ.size() > 0) ? lineQ[0] : 1'b1));
    check("busy", 32'(busy), 32'((lineQ.size() > 0) || (pendQ.size() > 0)));
    check("wdata_ready", 32'(wdata_ready), 32'(pendQ.size() < DEPTH));
  end

  // ---------------- line receiver ----------------
  int rstCount = 0;
  always @(negedge rst_n) rstCount <= rstCount + 1;

  initial begin : receiver
    int         startRst;
    logic [7:0] rxByte;
    logic       stopBit;
`ifdef UART_TX_PARITY_EN
    logic       parBit;
`endif
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        startRst = rstCount;
        repeat (D + D / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rxByte[i] = uart_tx;
          if (i < 7) repeat (D) @(negedge clk);
        end
`ifdef UART_TX_PARITY_EN
        repeat (D) @(negedge clk);
        parBit = uart_tx;
`endif
        repeat (D) @(negedge clk);
        stopBit = uart_tx;
        if (rstCount == startRst) begin
          rxQ.push_back(rxByte);
          check("rx_stop_bit", 32'(stopBit), 32'd1);
`ifdef UART_TX_PARITY_EN
          check("rx_parity", 32'(parBit), 32'(^rxByte));
`endif
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+2) ----------------
  task automatic pushOne(input logic [7:0] b);
    wdata = b;
    wdata_valid = 1'b1;
    @(posedge clk); #2;
    wdata_valid = 1'b0;
  endtask

  // Holds wdata_valid, advancing to the next byte whenever one is accepted.
  task automatic holdBytes(input int n, input logic [7:0] base);
    int idx = 0;
    int guard = 0;
    wdata = base;
    wdata_valid = 1'b1;
    while (idx < n && guard < 5000) begin
      @(posedge clk); #2;
      guard++;
      if (mAccept) idx++;
      if (guard == 17) check("fifo_full_ready", 32'(wdata_ready), 32'd0);
      wdata = base + 8'(idx);
    end
    wdata_valid = 1'b0;
    check("hold_accepted", 32'(idx), 32'(n));
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while ((lineQ.size() > 0 || pendQ.size() > 0) && n < bound) begin
      @(posedge clk); #2;
      n++;
    end
    check("idle_reached", 32'(n < bound), 32'd1);
    repeat (3) begin @(posedge clk); #2; end
  endtask

  // ---------------- directed tests ----------------
  logic [10:0] expA5;
  int          lowCount;
  int          n5;
  int          eeSeen;

  initial begin
`ifdef UART_TX_PARITY_EN
    expA5 = 11'b1_0_1010_0101_0;   // start, A5 LSB-first, parity 0, stop
`else
    expA5 = 11'b0_1_1010_0101_0;   // start, A5 LSB-first, stop
`endif
    #1 rst_n = 1'b0;
    #2;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(wdata_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    // Test 1: single byte A5
    pushOne(8'hA5);
    @(posedge clk);                    // pop edge
    for (int cyc = 0; cyc <= FRAME; cyc++) begin
      @(negedge clk);
      if (cyc < FRAME && (cyc % D) == D / 2)
        check("t1_bit", 32'(uart_tx), 32'(expA5[cyc / D]));
      if (cyc == FRAME - 1) check("t1_busy_last", 32'(busy), 32'd1);
      if (cyc == FRAME)     check("t1_busy_done", 32'(busy), 32'd0);
    end
    @(posedge clk); #2;

    // Test 2: 00 then FF back-to-back
    pushOne(8'h00);
    pushOne(8'hFF);
    for (int cyc = 0; cyc <= 2 * FRAME; cyc++) begin
      @(negedge clk);
      if (cyc >= FRAME - D && cyc < FRAME + D)
        check("t2_seam", 32'(uart_tx), 32'(cyc < FRAME));
      if (cyc == FRAME + D + D / 2) check("t2_ff_bit0", 32'(uart_tx), 32'd1);
      if (cyc == 2 * FRAME) check("t2_busy_done", 32'(busy), 32'd0);
    end
    @(posedge clk); #2;

    // Test 3: hold 20 bytes against a 16-deep FIFO
    holdBytes(20, 8'h10);
    waitIdle(5000);

    // Test 4: reset 35 clocks into a frame
    pushOne(8'h00);
    @(posedge clk);                    // pop edge
    repeat (35) @(posedge clk);
    #3;
    check("t4_line_low", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t4_rst_tx", 32'(uart_tx), 32'd1);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_ready", 32'(wdata_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    lowCount = 0;
    for (int cyc = 0; cyc < 150; cyc++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lowCount++;
    end
    check("t4_no_resend", 32'(lowCount), 32'd0);
    @(posedge clk); #2;

    // Test 5: push into a full FIFO on the STOP-end pop cycle
    holdBytes(17, 8'h40);
    n5 = 0;
    while (lineQ.size() != 1 && n5 < 500) begin
      @(posedge clk); #2;
      n5++;
    end
    check("t5_sync", 32'(lineQ.size()), 32'd1);
    wdata = 8'hEE;
    wdata_valid = 1'b1;
    @(negedge clk);
    check("t5_ready_full", 32'(wdata_ready), 32'd0);
    @(posedge clk); #2;
    wdata_valid = 1'b0;
    check("t5_rejected", 32'(mAccept), 32'd0);
    check("t5_ready_after_pop", 32'(wdata_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    waitIdle(5000);

`ifdef UART_TX_PARITY_EN
    // Test 6: parity of 07 is 1, frame is 110 clocks
    pushOne(8'h07);
    @(posedge clk);
    for (int cyc = 0; cyc <= FRAME; cyc++) begin
      @(negedge clk);
      if (cyc == 35)  check("t6_bit2", 32'(uart_tx), 32'd1);
      if (cyc == 45)  check("t6_bit3", 32'(uart_tx), 32'd0);
      if (cyc == 85)  check("t6_bit7", 32'(uart_tx), 32'd0);
      if (cyc == 95)  check("t6_parity", 32'(uart_tx), 32'd1);
      if (cyc == 105) check("t6_stop", 32'(uart_tx), 32'd1);
      if (cyc == 109) check("t6_busy_last", 32'(busy), 32'd1);
      if (cyc == 110) check("t6_busy_done", 32'(busy), 32'd0);
    end
    @(posedge clk); #2;
`endif

    repeat (20) @(posedge clk);
    #2;

    // Decoded bytes against the model log, plus hand-counted totals.
    check("rx_count", 32'(rxQ.size()), 32'(logQ.size()));
    for (int i = 0; i < rxQ.size() && i < logQ.size(); i++)
      check("rx_byte", 32'(rxQ[i]), 32'(logQ[i]));
`ifdef UART_TX_PARITY_EN
    check("rx_total", 32'(rxQ.size()), 32'd41);
`else
    check("rx_total", 32'(rxQ.size()), 32'd40);
`endif
    check("rx_first", 32'(rxQ[0]), 32'hA5);
    check("rx_second", 32'(rxQ[1]), 32'h00);
    check("rx_third", 32'(rxQ[2]), 32'hFF);
    check("rx_t3_last", 32'(rxQ[22]), 32'h23);
    eeSeen = 0;
    foreach (rxQ[i]) if (rxQ[i] == 8'hEE) eeSeen++;
    check("t5_ee_dropped", 32'(eeSeen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", nFail);
    $fatal(1);
  end

endmodule
